multicycle_control: RTL

Main control FSM of the multi-cycle MIPS datapath. It is the issuing side of the ALU interface: each cycle it drives the 4-bit ALU operation code and the operand-select muxes, and it consumes the ALU zero flag for branch resolution. It also sequences the PC, memory, instruction-register and register-file enables for fetch, decode, execute, memory and write-back.

---
 rtl/mips_ctrl_pkg.sv | 52 +++++
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control_alu_op_decoder.sv | 39 +++
 rtl/multicycle_control.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM:
// state enum, opcode/funct constants, ALU codes and mux-select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_I_EXEC    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0101;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic is_rtype_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_OR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
// Handshake-free: every output is a per-cycle level, valid for the whole cycle.
interface multicycle_control_if;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       pc_write_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic       zero_ext_o;
  logic [1:0] pc_src_o;
  logic [3:0] alu_operation_o;
  logic       illegal_o;

  modport master (
    input  opcode_i, funct_i, zero_i,
    output pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           zero_ext_o, pc_src_o, alu_operation_o, illegal_o
  );

  modport slave (
    output opcode_i, funct_i, zero_i,
    input  pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           zero_ext_o, pc_src_o, alu_operation_o, illegal_o
  );
endinterface

// File: rtl/multicycle_control_alu_op_decoder.sv
// Combinational ALU operation / immediate-extension decode from the current
// state and the instruction fields held in the IR.
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       zero_ext
);

  always_comb begin
    alu_op   = ALU_ADD;
    zero_ext = 1'b0;
    case (state)
      S_R_EXEC: begin
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_I_EXEC: begin
        case (opcode)
          OP_ORI: begin
            alu_op   = ALU_OR;
            zero_ext = 1'b1;
          end
          OP_LUI:  alu_op = ALU_LUI;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_BRANCH: alu_op = ALU_SUB;
      default:  alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Optional feature: define BNE_EN to decode opcode 0x05 as bne.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus,
  output state_t                 dbg_state
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign dbg_state = state_q;

  alu_op_decoder u_alu_op_decoder (
    .state    (state_q),
    .opcode   (bus.opcode_i),
    .funct    (bus.funct_i),
    .alu_op   (bus.alu_operation_o),
    .zero_ext (bus.zero_ext_o)
  );

  always_comb begin
    state_d          = state_q;
    bus.pc_write_o   = 1'b0;
    bus.i_or_d_o     = 1'b0;
    bus.mem_read_o   = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.ir_write_o   = 1'b0;
    bus.reg_write_o  = 1'b0;
    bus.reg_dst_o    = 1'b0;
    bus.mem_to_reg_o = 1'b0;
    bus.alu_src_a_o  = 1'b0;
    bus.alu_src_b_o  = SRC_B_REG;
    bus.pc_src_o     = PC_SRC_ALU;
    bus.illegal_o    = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.mem_read_o  = 1'b1;
        bus.ir_write_o  = 1'b1;
        bus.alu_src_b_o = SRC_B_FOUR;
        bus.pc_write_o  = 1'b1;
        state_d         = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_b_o = SRC_B_BRANCH;
        case (bus.opcode_i)
          OP_LW, OP_SW:          state_d = S_MEM_ADDR;
          OP_RTYPE:              state_d = is_rtype_funct(bus.funct_i) ? S_R_EXEC : S_ILLEGAL;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
`ifdef BNE_EN
          OP_BEQ, OP_BNE:        state_d = S_BRANCH;
`else
          OP_BEQ:                state_d = S_BRANCH;
`endif
          OP_J:                  state_d = S_JUMP;
          default:               state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = SRC_B_IMM;
        state_d         = (bus.opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        bus.i_or_d_o   = 1'b1;
        bus.mem_read_o = 1'b1;
        state_d        = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_write_o  = 1'b1;
        bus.mem_to_reg_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.i_or_d_o    = 1'b1;
        bus.mem_write_o = 1'b1;
        state_d         = S_FETCH;
      end
      S_R_EXEC, S_I_EXEC: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = (state_q == S_I_EXEC) ? SRC_B_IMM : SRC_B_REG;
        state_d         = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_write_o = 1'b1;
        bus.reg_dst_o   = (bus.opcode_i == OP_RTYPE);
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a_o = 1'b1;
        bus.pc_src_o    = PC_SRC_ALUOUT;
        // Only Mealy term: branch outcome comes straight from the ALU flag.
`ifdef BNE_EN
        bus.pc_write_o  = (bus.opcode_i == OP_BNE) ? !bus.zero_i : bus.zero_i;
`else
        bus.pc_write_o  = bus.zero_i;
`endif
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src_o   = PC_SRC_JUMP;
        bus.pc_write_o = 1'b1;
        state_d        = S_FETCH;
      end
      S_ILLEGAL: begin
        bus.illegal_o = 1'b1;
        state_d       = S_ILLEGAL;
      end
      default: state_d = S_ILLEGAL;
    endcase
  end

endmodule
